// File: rtl/comms_scheduler_pkg.sv
// Shared definitions for the telemetry frame scheduler: slot count,
// FSM states, timing defaults and the slot -> {mode, type} map.
package comms_pkg;

  localparam int NUM_SLOTS = 9;

  localparam int unsigned GAP_CYCLES_DEF   = 100000;
  localparam int unsigned MAX_RETRY_DEF    = 2;
  localparam int unsigned WAIT_TIMEOUT_DEF = 5000000;

  localparam logic [1:0] PROG_RUN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_WAIT,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] ftype;
  } frame_kind_t;

  // mode 00 is reserved; 01 = SWIPT, 10 = ANC, 11 = COMMS
  function automatic frame_kind_t slot_kind(input logic [3:0] slot);
    frame_kind_t k;
    case (slot)
      4'd0:    k = '{mode: 2'b01, ftype: 2'b00};
      4'd1:    k = '{mode: 2'b01, ftype: 2'b01};
      4'd2:    k = '{mode: 2'b01, ftype: 2'b10};
      4'd3:    k = '{mode: 2'b01, ftype: 2'b11};
      4'd4:    k = '{mode: 2'b10, ftype: 2'b00};
      4'd5:    k = '{mode: 2'b10, ftype: 2'b01};
      4'd6:    k = '{mode: 2'b11, ftype: 2'b00};
      4'd7:    k = '{mode: 2'b11, ftype: 2'b01};
      4'd8:    k = '{mode: 2'b11, ftype: 2'b10};
      default: k = '{mode: 2'b00, ftype: 2'b00};
    endcase
    return k;
  endfunction

endpackage

// File: rtl/comms_scheduler_if.sv
// Link-side frame handshake between the scheduler (master) and the
// physical link (slave).
interface comms_scheduler_if;
  logic        tx_req;
  logic        tx_ack;
  logic        tx_done;
  logic        tx_ok;
  logic [1:0]  tx_mode;
  logic [1:0]  tx_type;
  logic [15:0] tx_data;
  logic [3:0]  tx_slot;

  modport master (
    output tx_req, tx_mode, tx_type, tx_data, tx_slot,
    input  tx_ack, tx_done, tx_ok
  );

  modport slave (
    input  tx_req, tx_mode, tx_type, tx_data, tx_slot,
    output tx_ack, tx_done, tx_ok
  );
endinterface

// File: rtl/comms_scheduler_rr_pick.sv
// Combinational slot selector: lowest enabled pending-urgent slot first,
// otherwise the first enabled slot after rr_ptr (wrapping at NUM_SLOTS).
module rr_pick
  import comms_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] slot_en_i,
  input  logic [NUM_SLOTS-1:0] pending_i,
  input  logic [3:0]           rr_ptr_i,
  output logic                 valid_o,
  output logic                 urgent_o,
  output logic [3:0]           slot_o
);

  logic [NUM_SLOTS-1:0] urg;
  logic [4:0]           idx;

  always_comb begin
    urg      = slot_en_i & pending_i;
    valid_o  = 1'b0;
    urgent_o = 1'b0;
    slot_o   = '0;
    idx      = '0;
    if (|urg) begin
      valid_o  = 1'b1;
      urgent_o = 1'b1;
      for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
        if (urg[k]) slot_o = 4'(k);
      end
    end else begin
      // scan from farthest to nearest so the nearest enabled slot wins
      for (int i = NUM_SLOTS; i >= 1; i--) begin
        idx = 5'(rr_ptr_i) + 5'(i);
        if (idx >= 5'(NUM_SLOTS)) idx = idx - 5'(NUM_SLOTS);
        if (slot_en_i[idx[3:0]]) begin
          valid_o = 1'b1;
          slot_o  = idx[3:0];
        end
      end
    end
  end

endmodule

// File: rtl/comms_scheduler.sv
// Telemetry frame scheduler: picks a slot, requests the link, waits for
// completion with a watchdog, retries or drops, then idles for a gap.
//
//   state  | meaning
//   IDLE   | not running or nothing eligible
//   SELECT | one cycle: choose slot, latch frame
//   REQ    | tx_req high until tx_ack
//   WAIT   | waiting for tx_done, watchdog running
//   GAP    | inter-frame gap, then retry (REQ) or IDLE
module comms_scheduler
  import comms_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int unsigned MAX_RETRY    = MAX_RETRY_DEF,
  parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    swipt_alive_i,
  input  logic [1:0]              program_i,
  input  logic [16*NUM_SLOTS-1:0] slot_data_i,
  input  logic [NUM_SLOTS-1:0]    slot_en_i,
  input  logic [NUM_SLOTS-1:0]    urgent_i,
  comms_scheduler_if.master       tx,
  output logic                    busy_o,
  output logic                    fail_o,
  output logic [7:0]              err_cnt_o
);

  state_e               state_q;
  logic [3:0]           rr_ptr_q;
  logic [NUM_SLOTS-1:0] pending_q;
  logic [7:0]           retry_q;
  logic [7:0]           err_cnt_q;
  logic [31:0]          tmr_q;
  logic                 tx_req_q, busy_q, fail_q;
  logic [1:0]           tx_mode_q, tx_type_q;
  logic [15:0]          tx_data_q;
  logic [3:0]           tx_slot_q;

  logic                 pick_valid, pick_urgent;
  logic [3:0]           pick_slot;
  logic [15:0]          pick_data;
  frame_kind_t          pick_kind;
  logic                 run, tmr_zero, attempt_ok, attempt_bad, retry_left, complete;
  logic [NUM_SLOTS-1:0] clr_mask;

  rr_pick u_rr_pick (
    .slot_en_i (slot_en_i),
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr_q),
    .valid_o   (pick_valid),
    .urgent_o  (pick_urgent),
    .slot_o    (pick_slot)
  );

  always_comb begin
    run         = swipt_alive_i && (program_i == PROG_RUN);
    tmr_zero    = (tmr_q == '0);
    pick_data   = slot_data_i[16*pick_slot +: 16];
    pick_kind   = slot_kind(pick_slot);
    attempt_ok  = (state_q == ST_WAIT) && tx.tx_done && tx.tx_ok;
    attempt_bad = (state_q == ST_WAIT) &&
                  ((tx.tx_done && !tx.tx_ok) || (!tx.tx_done && tmr_zero));
    retry_left  = 32'(retry_q) < MAX_RETRY;
    complete    = run && (attempt_ok || (attempt_bad && !retry_left));
    clr_mask    = '0;
    if (complete) clr_mask[tx_slot_q] = 1'b1;
  end

  // a new urgent request outranks a completion of the same slot
  always_ff @(posedge clk) begin
    if (!nrst) pending_q <= '0;
    else       pending_q <= (pending_q & ~clr_mask) | (urgent_i & slot_en_i);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= 4'd8;
      retry_q   <= '0;
      err_cnt_q <= '0;
      tmr_q     <= '0;
      tx_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      fail_q    <= 1'b0;
      tx_mode_q <= '0;
      tx_type_q <= '0;
      tx_data_q <= '0;
      tx_slot_q <= '0;
    end else begin
      fail_q <= 1'b0;
      if (!run) begin
        state_q  <= ST_IDLE;
        tx_req_q <= 1'b0;
        busy_q   <= 1'b0;
        retry_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (|(slot_en_i | pending_q)) begin
              state_q <= ST_SELECT;
              busy_q  <= 1'b1;
            end
          end
          ST_SELECT: begin
            if (pick_valid) begin
              tx_slot_q <= pick_slot;
              tx_data_q <= pick_data;
              tx_mode_q <= pick_kind.mode;
              tx_type_q <= pick_kind.ftype;
              if (!pick_urgent) rr_ptr_q <= pick_slot;
              state_q  <= ST_REQ;
              tx_req_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          ST_REQ: begin
            if (tx.tx_ack) begin
              tx_req_q <= 1'b0;
              state_q  <= ST_WAIT;
              tmr_q    <= 32'(WAIT_TIMEOUT - 1);
            end
          end
          ST_WAIT: begin
            if (attempt_ok || attempt_bad) begin
              state_q <= ST_GAP;
              tmr_q   <= 32'(GAP_CYCLES - 1);
              if (attempt_ok) begin
                retry_q <= '0;
              end else if (retry_left) begin
                retry_q <= retry_q + 8'd1;
              end else begin
                retry_q <= '0;
                fail_q  <= 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              end
            end else begin
              tmr_q <= tmr_q - 32'd1;
            end
          end
          ST_GAP: begin
            if (tmr_zero) begin
              if (retry_q != '0) begin
                state_q  <= ST_REQ;
                tx_req_q <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tmr_q <= tmr_q - 32'd1;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            tx_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tx.tx_req  = tx_req_q;
  assign tx.tx_mode = tx_mode_q;
  assign tx.tx_type = tx_type_q;
  assign tx.tx_data = tx_data_q;
  assign tx.tx_slot = tx_slot_q;
  assign busy_o     = busy_q;
  assign fail_o     = fail_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: doc/comms_scheduler.md
COMMS_SCHEDULER -- requirements
Module: comms_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 100000, sets the idle gap between frames in clk cycles.
REQ-002 Parameter MAX_RETRY, default 2, sets the retries after a failed frame before the frame is dropped.
REQ-003 Parameter WAIT_TIMEOUT, default 5000000, sets the watchdog in cycles for tx_done while waiting.
REQ-004 clk  in  1  clock; reset nrst, synchronous, active-low.
REQ-005 swipt_alive  in  1  link power valid; program  in  2  operating program; the block runs only when swipt_alive=1 and program=2'b11 ("run").
REQ-006 slot_data  in  144  nine packed 16-bit telemetry values; slot k occupies bits [16k+15:16k].
REQ-007 slot_en  in  9  per-slot round-robin eligibility.
REQ-008 urgent  in  9  one-cycle pulses that request priority service of a slot.
REQ-009 tx_req  out  1; tx_ack  in  1  link accepted frame; tx_done  in  1  frame finished; tx_ok  in  1  result, sampled with tx_done.
REQ-010 tx_mode  out  2; tx_type  out  2; tx_data  out  16; tx_slot  out  4  describe the current frame.
REQ-011 busy  out  1; fail  out  1  one-cycle pulse on dropped frame; err_cnt  out  8  dropped-frame count.

Function
REQ-012 States IDLE, SELECT, REQ, WAIT, GAP; busy=1 in every state except IDLE.
REQ-013 IDLE->SELECT when run and (slot_en|pending) is nonzero.
REQ-014 SELECT lasts one cycle: lowest-index pending urgent slot among slot_en wins; otherwise round-robin starting at rr_ptr+1 mod 9 over slot_en; the state then goes to REQ.
REQ-015 SELECT latches tx_slot, tx_data=snapshot of slot_data, and tx_mode/tx_type from the package table; these outputs stay stable until the next SELECT.
REQ-016 rr_ptr updates to the served slot only for round-robin picks; urgent picks leave rr_ptr unchanged.
REQ-017 urgent[k] sets pending[k] only if slot_en[k]=1; pending is cleared when slot k completes; a set and a clear in the same cycle: set wins.
REQ-018 REQ drives tx_req=1 until the cycle tx_ack=1; tx_req=0 the following cycle; the state then goes to WAIT.
REQ-019 tx_done is honoured only in WAIT; tx_done in any other state is ignored.
REQ-020 WAIT, tx_done with tx_ok=1: retry count is cleared, the slot completes, and the state goes to GAP.
REQ-021 WAIT, tx_done with tx_ok=0, or the watchdog reaches WAIT_TIMEOUT: if retry count < MAX_RETRY, retry count increments and the state goes to GAP and then REQ with unchanged latched data.
REQ-022 When the retry count equals MAX_RETRY: fail pulses for 1 cycle, err_cnt increments and saturates at 255, the slot completes, and the state goes to GAP.
REQ-023 GAP counts exactly GAP_CYCLES cycles, then goes to REQ if a retry is outstanding, otherwise to IDLE.
REQ-024 Loss of run in any state: the next state is IDLE, tx_req=0, the retry count and latched frame are discarded, and pending, rr_ptr and err_cnt are kept.
REQ-025 All 9 slots disabled with no pending: the block remains in IDLE.

Reset
REQ-026 nrst=0: state=IDLE, tx_req=0, tx_mode=0, tx_type=0, tx_data=0, tx_slot=0, busy=0, fail=0, err_cnt=0, pending=0, retry count=0, rr_ptr=8 (first round-robin pick is slot 0).
REQ-027 Reset mid-frame takes effect on the next clk edge; no frame resumes after reset.

Structure
REQ-028 Package comms_pkg holds the slot count (9), the state enum, the GAP_CYCLES, MAX_RETRY and WAIT_TIMEOUT defaults, and the slot->{mode,type} table.
REQ-029 Slot table: slots 0-3 are SWIPT P_TX, DUTY, FREQ, ASCII with mode 01 and type 00..11.
REQ-030 Slot table: slots 4-5 are ANC MAX and MIN height with mode 10 and type 00..01.
REQ-031 Slot table: slots 6-8 are COMMS TRAJECT, QR_CODES, FLIGHT_TIME with mode 11 and type 00..10; mode 00 is reserved.
REQ-032 The block contains one combinational sub-module, rr_pick (urgent-priority / round-robin selector).

Verification
REQ-033 Scenario: slot_en=9'h003, ack 1 cycle after tx_req, done ok 10 cycles later, GAP_CYCLES=4 -> slot order 0,1,0,1; tx_mode/type 01/00 then 01/01; tx_data equals the slot value.
REQ-034 Scenario: slot_en=9'h1FF, urgent[7] pulse during the slot-0 frame -> next frame is slot 7 (mode 11, type 01), then slot 1.
REQ-035 Scenario: MAX_RETRY=2, tx_ok=0 on every done -> 3 tx_req with identical tx_data, fail pulse, err_cnt=1, then the next slot is served.
REQ-036 Scenario: WAIT_TIMEOUT=50, no tx_done -> retry issued after 50 cycles plus GAP.
REQ-037 Scenario: program changes to 2'b10 during WAIT -> next cycle busy=0 and tx_req=0; on return to 2'b11, round robin continues from the kept rr_ptr.
REQ-038 Scenario: 256 forced drops -> err_cnt holds at 255; nrst=0 mid-REQ -> all outputs at REQ-026 values next cycle.
